// File: rtl/ysyx_050518_lsu_ctrl_if.sv
// Bundle of the request, dcache, MMIO and response channels of the LSU controller.
// Every channel uses valid/ready (or req/ack) semantics: a transfer happens in
// the cycle where both the offer (valid/req) and the acceptance (ready/ack) are high.
interface ysyx_050518_lsu_ctrl_if #(
    parameter int XLEN    = 64,
    parameter int AW      = 64,
    parameter int MMIO_DW = 32
);
    // Request channel
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [2:0]          req_func3;
    logic [AW-1:0]       req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic [4:0]          req_rd;
    // Dcache port
    logic                dc_req;
    logic                dc_we;
    logic [AW-1:0]       dc_addr;
    logic [XLEN/8-1:0]   dc_wstrb;
    logic [XLEN-1:0]     dc_wdata;
    logic [XLEN-1:0]     dc_rdata;
    logic                dc_ack;
    // MMIO port
    logic                io_req;
    logic                io_we;
    logic [AW-1:0]       io_addr;
    logic [2:0]          io_size;
    logic [MMIO_DW-1:0]  io_wdata;
    logic [MMIO_DW-1:0]  io_rdata;
    logic                io_ack;
    // Response channel
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_rd_we;
    logic [4:0]          resp_rd;
    logic [XLEN-1:0]     resp_data;
    logic                resp_err;

    // Environment side: issues requests, models the memories, consumes responses
    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  dc_req, dc_we, dc_addr, dc_wstrb, dc_wdata,
        output dc_rdata, dc_ack,
        input  io_req, io_we, io_addr, io_size, io_wdata,
        output io_rdata, io_ack,
        input  resp_valid, resp_rd_we, resp_rd, resp_data, resp_err,
        output resp_ready
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
        output req_ready,
        output dc_req, dc_we, dc_addr, dc_wstrb, dc_wdata,
        input  dc_rdata, dc_ack,
        output io_req, io_we, io_addr, io_size, io_wdata,
        input  io_rdata, io_ack,
        output resp_valid, resp_rd_we, resp_rd, resp_data, resp_err,
        input  resp_ready
    );
endinterface

// File: rtl/ysyx_050518_lsu_ctrl.sv
// Memory-stage load/store controller: accepts one request, routes it to the
// dcache or the MMIO bus by address window, aligns store data/strobes,
// extends load data and returns a registered response. dbg_state exposes the FSM.
module ysyx_050518_lsu_ctrl #(
    parameter int           XLEN    = 64,
    parameter int           AW      = 64,
    parameter logic [3:0]   MMIO_HI = 4'ha,
    parameter int           MMIO_DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_050518_lsu_ctrl_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int OW = $clog2(XLEN / 8);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DC_WAIT = 2'd1;
    localparam logic [1:0] IO_WAIT = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]       state;
    logic             we_q;
    logic [2:0]       func3_q;
    logic [AW-1:0]    addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  data_q;
    logic             err_q;
    logic             rd_we_q;

    logic             accept;
    logic             is_io;
    logic [3:0]       req_size;
    logic             misaligned;
    logic             illegal;
    logic [3:0]       size_q;
    logic [OW-1:0]    offset;
    logic [OW+2:0]    shamt;
    logic [XLEN/8-1:0] size_mask;

    // Sign/zero extension of LSB-justified load data from bit 8*size-1
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = XLEN'($signed(raw[7:0]));
            3'b001:  r = XLEN'($signed(raw[15:0]));
            3'b010:  r = XLEN'($signed(raw[31:0]));
            3'b100:  r = XLEN'(raw[7:0]);
            3'b101:  r = XLEN'(raw[15:0]);
            3'b110:  r = XLEN'(raw[31:0]);
            default: r = raw;
        endcase
        return r;
    endfunction

    assign accept   = bus.req_valid && (state == IDLE);
    assign is_io    = (bus.req_addr[31:28] == MMIO_HI);
    assign req_size = 4'd1 << bus.req_func3[1:0];

    // Alignment check against the access size of the incoming request
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_func3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            2'b11:   misaligned = |bus.req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign illegal = (bus.req_func3 == 3'b111)
                  || (bus.req_we && bus.req_func3[2])
                  || ((XLEN == 32) && (bus.req_func3[1:0] == 2'b11))
                  || (is_io && (req_size > 4'(MMIO_DW / 8)))
                  || misaligned;

    // State and latched request/response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            func3_q <= 3'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rd_we_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        func3_q <= bus.req_func3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        rd_q    <= bus.req_rd;
                        data_q  <= '0;
                        rd_we_q <= 1'b0;
                        err_q   <= illegal;
                        if (illegal)    state <= RESP;
                        else if (is_io) state <= IO_WAIT;
                        else            state <= DC_WAIT;
                    end
                end
                DC_WAIT: begin
                    if (bus.dc_ack) begin
                        data_q  <= we_q ? '0 : extend(bus.dc_rdata >> shamt, func3_q);
                        rd_we_q <= !we_q;
                        state   <= RESP;
                    end
                end
                IO_WAIT: begin
                    if (bus.io_ack) begin
                        data_q  <= we_q ? '0 : extend(XLEN'(bus.io_rdata), func3_q);
                        rd_we_q <= !we_q;
                        state   <= RESP;
                    end
                end
                default: begin
                    if (bus.resp_ready) state <= IDLE;
                end
            endcase
        end
    end

    assign size_q    = 4'd1 << func3_q[1:0];
    assign offset    = addr_q[OW-1:0];
    assign shamt     = {offset, 3'b000};
    // size_q ones; a full-width shift clears everything so the mask becomes all ones
    assign size_mask = ~({(XLEN / 8){1'b1}} << size_q);

    assign bus.req_ready  = (state == IDLE);

    assign bus.dc_req     = (state == DC_WAIT);
    assign bus.dc_we      = bus.dc_req && we_q;
    assign bus.dc_addr    = addr_q & ~AW'(XLEN / 8 - 1);
    assign bus.dc_wstrb   = bus.dc_we ? (size_mask << offset) : '0;
    assign bus.dc_wdata   = wdata_q << shamt;

    assign bus.io_req     = (state == IO_WAIT);
    assign bus.io_we      = bus.io_req && we_q;
    assign bus.io_addr    = addr_q;
    assign bus.io_size    = {1'b0, func3_q[1:0]};
    assign bus.io_wdata   = wdata_q[MMIO_DW-1:0];

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rd_we = bus.resp_valid && rd_we_q;
    assign bus.resp_rd    = rd_q;
    assign bus.resp_data  = data_q;
    assign bus.resp_err   = bus.resp_valid && err_q;

    assign dbg_state      = state;
endmodule

// File: tb/tb_ysyx_050518_lsu_ctrl.sv
// Directed bench for the LSU controller (XLEN=64, MMIO_DW=32).
module tb_ysyx_050518_lsu_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DC   = 2'd1;
    localparam logic [1:0] S_IO   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;

    ysyx_050518_lsu_ctrl_if #(.XLEN(64), .AW(64), .MMIO_DW(32)) bus ();

    ysyx_050518_lsu_ctrl #(.XLEN(64), .AW(64), .MMIO_HI(4'ha), .MMIO_DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_rd    = rd;
    endtask

    task automatic drain(input string tag);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check(tag, 64'(dbg_state), 64'(S_IDLE));
        check({tag, "_rdy"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_func3 = 3'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = 5'd0;
        bus.dc_rdata = '0; bus.dc_ack = 1'b0;
        bus.io_rdata = '0; bus.io_ack = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_dc_req", 64'(bus.dc_req), 64'd0);
        check("rst_io_req", 64'(bus.io_req), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", bus.resp_data, 64'd0);
        rst = 1'b0;

        // lw from dcache, ack after 2 cycles
        offer(1'b0, 3'b010, 64'h8000_0004, 64'd0, 5'd5);
        step();
        bus.req_valid = 1'b0;
        check("lw_state", 64'(dbg_state), 64'(S_DC));
        check("lw_dc_req", 64'(bus.dc_req), 64'd1);
        check("lw_dc_addr", bus.dc_addr, 64'h8000_0000);
        check("lw_dc_wstrb", 64'(bus.dc_wstrb), 64'd0);
        check("lw_req_ready", 64'(bus.req_ready), 64'd0);
        step();
        check("lw_dc_req_hold", 64'(bus.dc_req), 64'd1);
        bus.dc_rdata = 64'h8765_4321_0000_0000;
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        check("lw_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("lw_resp_data", bus.resp_data, 64'hFFFF_FFFF_8765_4321);
        check("lw_rd_we", 64'(bus.resp_rd_we), 64'd1);
        check("lw_rd", 64'(bus.resp_rd), 64'd5);
        check("lw_err", 64'(bus.resp_err), 64'd0);
        check("lw_dc_req_off", 64'(bus.dc_req), 64'd0);
        drain("lw_idle");
        check("lw_resp_gone", 64'(bus.resp_valid), 64'd0);

        // sb to dcache, immediate ack
        offer(1'b1, 3'b000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 5'd0);
        step();
        bus.req_valid = 1'b0;
        check("sb_dc_we", 64'(bus.dc_we), 64'd1);
        check("sb_dc_wstrb", 64'(bus.dc_wstrb), 64'h08);
        check("sb_dc_wdata", bus.dc_wdata, 64'h0000_0000_AB00_0000);
        bus.dc_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        check("sb_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("sb_rd_we", 64'(bus.resp_rd_we), 64'd0);
        check("sb_resp_data", bus.resp_data, 64'd0);
        drain("sb_idle");

        // lhu from MMIO; a stray dc_ack must be ignored
        offer(1'b0, 3'b101, 64'hA000_0000, 64'd0, 5'd3);
        step();
        bus.req_valid = 1'b0;
        check("lhu_io_req", 64'(bus.io_req), 64'd1);
        check("lhu_io_size", 64'(bus.io_size), 64'd1);
        check("lhu_io_addr", bus.io_addr, 64'hA000_0000);
        check("lhu_dc_req", 64'(bus.dc_req), 64'd0);
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        check("lhu_stray_ack", 64'(dbg_state), 64'(S_IO));
        bus.io_rdata = 32'h0000_F00D;
        bus.io_ack = 1'b1;
        step();
        bus.io_ack = 1'b0;
        check("lhu_resp_data", bus.resp_data, 64'h0000_0000_0000_F00D);
        check("lhu_rd_we", 64'(bus.resp_rd_we), 64'd1);
        drain("lhu_idle");

        // sw to MMIO
        offer(1'b1, 3'b010, 64'hA000_0010, 64'h1122_3344_5566_7788, 5'd0);
        step();
        bus.req_valid = 1'b0;
        check("sw_io_we", 64'(bus.io_we), 64'd1);
        check("sw_io_wdata", 64'(bus.io_wdata), 64'h5566_7788);
        check("sw_io_size", 64'(bus.io_size), 64'd2);
        bus.io_ack = 1'b1;
        step();
        bus.io_ack = 1'b0;
        check("sw_rd_we", 64'(bus.resp_rd_we), 64'd0);
        drain("sw_idle");

        // Misaligned lw: error response one cycle after accept
        offer(1'b0, 3'b010, 64'h8000_0002, 64'd0, 5'd4);
        step();
        bus.req_valid = 1'b0;
        check("mis_state", 64'(dbg_state), 64'(S_RESP));
        check("mis_dc_req", 64'(bus.dc_req), 64'd0);
        check("mis_io_req", 64'(bus.io_req), 64'd0);
        check("mis_err", 64'(bus.resp_err), 64'd1);
        check("mis_rd_we", 64'(bus.resp_rd_we), 64'd0);
        check("mis_data", bus.resp_data, 64'd0);
        drain("mis_idle");

        // ld to 32-bit MMIO is illegal
        offer(1'b0, 3'b011, 64'hA000_0008, 64'd0, 5'd4);
        step();
        bus.req_valid = 1'b0;
        check("ldio_err", 64'(bus.resp_err), 64'd1);
        check("ldio_io_req", 64'(bus.io_req), 64'd0);
        drain("ldio_idle");

        // Store with func3[2] set is illegal
        offer(1'b1, 3'b100, 64'h8000_0000, 64'd0, 5'd0);
        step();
        bus.req_valid = 1'b0;
        check("st100_err", 64'(bus.resp_err), 64'd1);
        drain("st100_idle");

        // lb with resp_ready held low 5 cycles while a new request waits
        offer(1'b0, 3'b000, 64'h8000_0001, 64'd0, 5'd7);
        step();
        bus.req_valid = 1'b0;
        bus.dc_rdata = 64'h0000_0000_0000_8000;
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        offer(1'b0, 3'b010, 64'hA000_0004, 64'd0, 5'd9);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(bus.resp_valid), 64'd1);
            check("hold_data", bus.resp_data, 64'hFFFF_FFFF_FFFF_FF80);
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            step();
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check("hold_idle", 64'(dbg_state), 64'(S_IDLE));
        check("hold_req_ready_up", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 1'b0;
        check("next_io_req", 64'(bus.io_req), 64'd1);
        check("next_io_addr", bus.io_addr, 64'hA000_0004);
        bus.io_rdata = 32'h8000_0000;
        bus.io_ack = 1'b1;
        step();
        bus.io_ack = 1'b0;
        check("next_data", bus.resp_data, 64'hFFFF_FFFF_8000_0000);
        check("next_rd", 64'(bus.resp_rd), 64'd9);
        drain("next_idle");

        // Async reset in the middle of DC_WAIT
        offer(1'b0, 3'b011, 64'h8000_0008, 64'd0, 5'd2);
        step();
        bus.req_valid = 1'b0;
        check("arst_dc_req_before", 64'(bus.dc_req), 64'd1);
        check("arst_dc_addr", bus.dc_addr, 64'h8000_0008);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dc_req", 64'(bus.dc_req), 64'd0);
        check("arst_state", 64'(dbg_state), 64'(S_IDLE));
        check("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
        step();
        rst = 1'b0;
        bus.dc_rdata = 64'h1234_5678_9ABC_DEF0;
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        check("late_ack_valid", 64'(bus.resp_valid), 64'd0);
        check("late_ack_state", 64'(dbg_state), 64'(S_IDLE));
        step();
        check("late_ack_valid2", 64'(bus.resp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
